// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_CODE_PAUSE = 8'h77;
  localparam int unsigned PS2_PAUSE_LEN = 7;
  localparam int unsigned PS2_JUNK_N    = 8;
  localparam logic [7:0] PS2_JUNK [PS2_JUNK_N] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  typedef struct packed {
    logic       rel;
    logic       extended;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } dec_state_t;

  // Controller status / acknowledge bytes that never form part of a keystroke.
  function automatic logic is_junk(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(PS2_JUNK_N); i++) begin
      if (b == PS2_JUNK[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && (count_q != '0);

  // Head register looks ahead to the word that will sit at the read pointer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + CW'(1);
    else if (!do_wr && do_rd) count_d = count_q - CW'(1);
    if (count_d != '0) begin
      if (do_wr && (wr_ptr_q == rd_ptr_d)) head_d = wr_data;
      else head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign rd_data = head_q;
  assign valid   = valid_q;
  assign count   = count_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 byte stream to key-event FIFO with IRQ.
// Optional PS2_KEY_DECODER_TYPEMATIC_FILTER_EN drops repeated make events.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [9:0]    evt_data,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] fifo_count,
  output logic          err,
  output logic          irq
);

  dec_state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       err_q, err_d;
  logic       run_q;
  logic       fifo_full;
  logic       accept;
  logic       cand_push, cand_pause, push_c;
  key_event_t cand_evt;

  // Held low through reset so in_ready reads 0 while rst_n is asserted.
  assign in_ready = run_q && !fifo_full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    err_d      = 1'b0;
    cand_push  = 1'b0;
    cand_pause = 1'b0;
    cand_evt   = '0;
    cand_evt.code = in_data;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_data == PS2_PFX_EXT) state_d = EXT;
          else if (in_data == PS2_PFX_BRK) state_d = BRK;
          else if (in_data == PS2_PFX_PAUSE) begin
            state_d = SKIP;
            skip_d  = 3'(PS2_PAUSE_LEN);
          end else if (is_junk(in_data)) err_d = 1'b1;
          else cand_push = 1'b1;
        end
        EXT: begin
          if (in_data == PS2_PFX_BRK) state_d = EXT_BRK;
          else if (in_data != PS2_PFX_EXT) begin
            cand_push         = 1'b1;
            cand_evt.extended = 1'b1;
            state_d           = IDLE;
          end
        end
        BRK: begin
          cand_push    = 1'b1;
          cand_evt.rel = 1'b1;
          state_d      = IDLE;
        end
        EXT_BRK: begin
          cand_push         = 1'b1;
          cand_evt.rel      = 1'b1;
          cand_evt.extended = 1'b1;
          state_d           = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            cand_push         = 1'b1;
            cand_pause        = 1'b1;
            cand_evt.extended = 1'b1;
            cand_evt.code     = PS2_CODE_PAUSE;
            state_d           = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      skip_q  <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

`ifdef PS2_KEY_DECODER_TYPEMATIC_FILTER_EN
  logic       lm_valid_q, lm_valid_d;
  logic       lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       lm_match;

  assign lm_match = lm_valid_q && (lm_ext_q == cand_evt.extended) &&
                    (lm_code_q == cand_evt.code);

  // Typematic repeats of the last held key are swallowed; its break re-arms.
  always_comb begin
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    push_c     = cand_push;
    if (cand_push && !cand_pause) begin
      if (!cand_evt.rel) begin
        if (lm_match) push_c = 1'b0;
        else begin
          lm_valid_d = 1'b1;
          lm_ext_d   = cand_evt.extended;
          lm_code_d  = cand_evt.code;
        end
      end else if (lm_match) lm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= '0;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end
`else
  assign push_c = cand_push;
`endif

  sync_fifo #(
    .WIDTH($bits(key_event_t)),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push_c),
    .wr_data(cand_evt),
    .rd_en  (evt_ready),
    .rd_data(evt_data),
    .valid  (evt_valid),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  assign err = err_q;
  assign irq = evt_valid;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (DEPTH=8).
module tb_ps2_key_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    evt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] fifo_count;
  logic          err;
  logic          irq;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int irq_bad = 0;
  logic irq_seen = 1'b0;
  logic [9:0] got [$];

  ps2_key_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .fifo_count(fifo_count),
    .err       (err),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Records each popped event, err pulses and irq/evt_valid agreement.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (err) err_cnt++;
      if (irq !== evt_valid) irq_bad++;
      if (irq) irq_seen = 1'b1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_%h: in_ready=%b after %0d cycles, required 1", b, in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    evt_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, evt_valid, evt_data, fifo_count, err, irq} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b v=%b d=%h cnt=%0d err=%b irq=%b, required all 0",
               in_ready, evt_valid, evt_data, fifo_count, err, irq);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_make_break();
    logic [9:0] exp [$];
    exp = '{10'h01C, 10'h21C};
    got.delete();
    irq_seen = 1'b0;
    evt_ready = 1'b1;
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_cycles(4);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL make_break_count: got %0d events required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL make_break_evt%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    @(negedge clk);
    total++;
    if (fifo_count !== CW'(0) || irq !== 1'b0 || irq_seen !== 1'b1) begin
      bad++;
      $display("FAIL make_break_idle: cnt=%0d irq=%b irq_seen=%b required 0/0/1",
               fifo_count, irq, irq_seen);
    end
  endtask

  task automatic test_extended();
    logic [9:0] exp [$];
    int e0;
    exp = '{10'h175, 10'h375};
    got.delete();
    e0 = err_cnt;
    evt_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    wait_cycles(4);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL ext_count: got %0d events required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL ext_evt%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    total++;
    if (err_cnt != e0) begin
      bad++;
      $display("FAIL ext_no_err: err pulses %0d required 0", err_cnt - e0);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [$];
    logic [9:0] exp [$];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    exp = '{10'h177, 10'h01C};
    got.delete();
    evt_ready = 1'b1;
    foreach (seq[i]) send_byte(seq[i]);
    wait_cycles(4);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL pause_count: got %0d events required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL pause_evt%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_full();
    got.delete();
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h15 + 8'(i));
    @(negedge clk);
    total++;
    if (fifo_count !== CW'(8) || in_ready !== 1'b0 || evt_data !== 10'h015) begin
      bad++;
      $display("FAIL full_state: cnt=%0d rdy=%b head=%h required 8/0/015",
               fifo_count, in_ready, evt_data);
    end
    in_data  = 8'h1D;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (fifo_count !== CW'(8) || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_hold: cnt=%0d rdy=%b required 8/0", fifo_count, in_ready);
    end
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
    @(negedge clk);
    total++;
    if (fifo_count !== CW'(7) || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_after_pop: cnt=%0d rdy=%b required 7/1", fifo_count, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (fifo_count !== CW'(8) || evt_data !== 10'h016) begin
      bad++;
      $display("FAIL full_refill: cnt=%0d head=%h required 8/016", fifo_count, evt_data);
    end
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    wait_cycles(12);
    total++;
    if (got.size() != 9) begin
      bad++;
      $display("FAIL full_drain_count: got %0d events required 9", got.size());
    end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 10'h015 + 10'(i)) begin
        bad++;
        $display("FAIL full_drain_evt%0d: got %h required %h", i, got[i], 10'h015 + 10'(i));
      end
    end
    total++;
    if (fifo_count !== CW'(0)) begin
      bad++;
      $display("FAIL full_drained: cnt=%0d required 0", fifo_count);
    end
  endtask

  task automatic test_junk();
    int e0;
    got.delete();
    e0 = err_cnt;
    evt_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hFA);
    wait_cycles(3);
    total++;
    if (err_cnt - e0 != 2 || got.size() != 0) begin
      bad++;
      $display("FAIL junk: err pulses %0d events %0d required 2/0", err_cnt - e0, got.size());
    end
  endtask

  task automatic test_reset_mid_prefix();
    got.delete();
    evt_ready = 1'b1;
    send_byte(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: rdy=%b v=%b required 0/0", in_ready, evt_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);
    send_byte(8'h1C);
    wait_cycles(3);
    total++;
    if (got.size() != 1 || (got.size() == 1 && got[0] !== 10'h01C)) begin
      bad++;
      $display("FAIL reset_mid_prefix: events %0d first %h required 1 event 01C",
               got.size(), got.size() > 0 ? got[0] : 10'h0);
    end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [$];
    logic [9:0] exp [$];
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_KEY_DECODER_TYPEMATIC_FILTER_EN
    exp = '{10'h01C, 10'h21C, 10'h01C};
`else
    exp = '{10'h01C, 10'h01C, 10'h01C, 10'h21C, 10'h01C};
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);
    got.delete();
    evt_ready = 1'b1;
    foreach (seq[i]) send_byte(seq[i]);
    wait_cycles(4);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL typematic_count: got %0d events required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL typematic_evt%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_full();
    test_junk();
    test_reset_mid_prefix();
    test_typematic();
    total++;
    if (irq_bad != 0) begin
      bad++;
      $display("FAIL irq_tracks_valid: %0d cycles differ, required 0", irq_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Downstream consumer of the PS/2 byte receiver. Takes raw 8-bit scan-code set 2 bytes over a valid/ready stream.
- Strips E0/F0/E1 prefixes and emits one key event per keystroke: {release, extended, code}.
- Events are buffered in a small FIFO for the CPU-facing peripheral, with an IRQ while non-empty.

Parameters:
- DEPTH, 8, event FIFO depth in entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of fifo_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  8  scan-code byte from the receiver.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  decoder accepts the byte this cycle.
- evt_data  out  10  event at the FIFO head: [9]=release, [8]=extended, [7:0]=code.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer pops the head this cycle.
- fifo_count  out  CW  current occupancy.
- err  out  1  one-cycle pulse when a junk byte is discarded.
- irq  out  1  equals evt_valid.

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE and the FIFO empties. All outputs are 0: in_ready, evt_valid, evt_data, fifo_count, err, irq. Reset takes effect immediately, even mid-prefix or mid-skip; partial sequences are discarded.
- Input handshake: in_ready = !full (combinational from registered occupancy). A byte is consumed when in_valid && in_ready. Prefix bytes also require in_ready.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- From IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip_cnt=7.
  - 00, AA, EE, FA, FC, FD, FE, FF -> discarded, err pulses next cycle, stay IDLE.
  - Any other byte -> push {0,0,byte}, stay IDLE.
- From EXT: F0 -> EXT_BRK; E0 -> stay EXT (redundant prefix); any other byte -> push {0,1,byte}, go to IDLE.
- From BRK: push {1,0,byte}, go to IDLE.
- From EXT_BRK: push {1,1,byte}, go to IDLE.
- From SKIP:
  - Each consumed byte decrements skip_cnt.
  - On the byte where skip_cnt==1, push {0,1,8'h77} (Pause) and go to IDLE.
  - Byte values are not inspected in SKIP.
- Push timing: the FIFO write happens on the clock edge that consumes the terminal byte. The entry is visible on evt_valid and evt_data in the next cycle.
- FIFO:
  - Show-ahead; evt_data is registered from the head entry.
  - Pop on evt_valid && evt_ready.
  - Push and pop in the same cycle: count is unchanged, pointers both advance; legal when full because in_ready is already 0 in that case, so only the pop occurs.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
  - count is CW bits wide and ranges 0..DEPTH.
- Empty: evt_valid=0; evt_data holds its last value; don't-care.
- Full: in_ready=0. The upstream receiver holds its byte; nothing is lost inside this block.
- err is a registered single-cycle pulse. It does not change the FSM state.

Optional Feature:
- Macro: PS2_KEY_DECODER_TYPEMATIC_FILTER_EN.
- Defined:
  - Registers last_make {valid, ext, code}.
  - A make event equal to last_make is suppressed: byte consumed, no push, FSM returns to IDLE.
  - Any other make updates last_make.
  - A break whose {ext,code} matches last_make clears valid.
  - Pause never updates last_make.
  - Reset clears valid.
- Undefined: every make event is pushed, including typematic repeats. No extra registers.

Decomposition:
- Package ps2_pkg holds:
  - key_event_t: packed struct {release, extended, code[7:0]}.
  - State enum dec_state_t.
  - Localparams: PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_PAUSE_LEN=7, and the junk-byte list.
- One sub-module, sync_fifo, parameterised on WIDTH and DEPTH: async active-low reset, show-ahead, count output. The decoder instantiates it with WIDTH=$bits(key_event_t).

Test Plan:
- Bytes 1C, F0 1C with evt_ready=1 -> events 0x01C then 0x21C; fifo_count returns to 0; irq high only while an event is pending.
- Bytes E0 75, E0 F0 75 -> events 0x175 then 0x375; no err pulse.
- Bytes E1 14 77 E1 F0 14 F0 77, then 1C -> exactly two events, 0x177 then 0x01C.
- evt_ready=0, 9 make codes with DEPTH=8 -> 8 pushed, fifo_count=8, in_ready=0, 9th byte held. Then one pop -> 9th byte accepted next cycle, count stays 8.
- Byte AA then byte FA -> two err pulses, no events. Separately, E0 then rst_n low for 1 cycle, then 1C -> event 0x01C, not extended.
- With the filter macro: 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C. Without it -> five events.
